ssd_scan_ctrl: RTL and testbench

//  Parametrised multiplexed seven-segment scan controller; next generation of the 8-digit display driver.

---
 rtl/ssd_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl
//   Time-multiplexed seven-segment scan controller. It drives N_DIGITS raw segment
//   patterns onto one shared segment bus and a one-hot anode bus. Each digit has
//   an enable and a blink control. A PWM brightness setting and a frame strobe
//   are also provided.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   seg_in      digit i at [8i+7:8i] = {p,g,f,e,d,c,b,a}, 1 = segment lit
//   digit_en    0 forces digit i dark
//   blink_en    1 makes digit i blink with the frame-based blink phase
//   brightness  0 = minimum duty (1/2**BRIGHT_W), all ones = full duty
//   seg_out     registered segment bus, polarity per ACTIVE_LOW
//   an          registered one-hot anode select, polarity per ACTIVE_LOW
//   frame_tick  1-cycle pulse on the first output cycle of digit 0 of each frame
module ssd_scan_ctrl #(
    parameter int N_DIGITS     = 8,
    parameter int STEP_CYCLES  = 6250,
    parameter int BRIGHT_W     = 4,
    parameter int BLINK_FRAMES = 200,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*N_DIGITS-1:0] seg_in,
    input  logic [N_DIGITS-1:0]   digit_en,
    input  logic [N_DIGITS-1:0]   blink_en,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            seg_out,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_tick
);

    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int SUB_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam int FR_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(STEP_CYCLES - 1);
    localparam logic [FR_W-1:0]  FR_LAST  = FR_W'(BLINK_FRAMES - 1);

    // XOR masks: an output equals its active-high value XOR these masks.
    localparam logic [N_DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [7:0]          SEG_OFF = (ACTIVE_LOW != 0) ? '1 : '0;

    logic [SUB_W-1:0]    sub_cnt;
    logic [BRIGHT_W-1:0] pwm_step;
    logic [IDX_W-1:0]    idx;
    logic [FR_W-1:0]     frame_cnt;
    logic                blink_phase;
    logic [BRIGHT_W-1:0] bright_q;

    logic                sub_wrap;
    logic                step_wrap;
    logic                slot_start;
    logic                frame_end;
    logic [7:0]          cur_seg;
    logic                cur_en;
    logic                cur_blk;
    logic                lit;
    logic [N_DIGITS-1:0] an_act;

    always_comb begin
        sub_wrap   = (sub_cnt == SUB_LAST);
        step_wrap  = (pwm_step == '1);
        slot_start = (sub_cnt == '0) && (pwm_step == '0);
        frame_end  = sub_wrap && step_wrap && (idx == IDX_LAST);

        cur_seg = '0;
        cur_en  = 1'b0;
        cur_blk = 1'b0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_seg = seg_in[8*i +: 8];
                cur_en  = digit_en[i];
                cur_blk = blink_en[i];
            end
        end

        // On the first cycle of a slot bright_q still holds the previous slot's
        // value, but pwm_step is 0 there, so the compare is true regardless.
        lit = cur_en & ~(cur_blk & blink_phase) & (pwm_step <= bright_q);

        an_act = '0;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            an_act[i] = lit && (idx == IDX_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sub_cnt     <= '0;
            pwm_step    <= '0;
            idx         <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            bright_q    <= '0;
            frame_tick  <= 1'b0;
            an          <= AN_OFF;
            seg_out     <= SEG_OFF;
        end else begin
            sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;

            if (sub_wrap) begin
                pwm_step <= pwm_step + 1'b1;
            end

            if (sub_wrap && step_wrap) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end

            if (slot_start) begin
                bright_q <= brightness;
            end

            if (frame_end) begin
                if (frame_cnt == FR_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            an         <= an_act ^ AN_OFF;
            seg_out    <= (lit ? cur_seg : 8'h00) ^ SEG_OFF;
            frame_tick <= slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl
//   Self-checking bench for ssd_scan_ctrl with 4 digits, 2-cycle PWM steps,
//   2-bit brightness, 2-frame blink half-period and active-low outputs.
//   The bench uses an 8-cycle slot and a 32-cycle frame.
module tb_ssd_scan_ctrl;

    localparam int N    = 4;
    localparam int STEP = 2;
    localparam int BW   = 2;
    localparam int BF   = 2;
    localparam int SLOT = STEP * (1 << BW);
    localparam int FRAME = SLOT * N;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [8*N-1:0] seg_in = '0;
    logic [N-1:0]  digit_en = '0;
    logic [N-1:0]  blink_en = '0;
    logic [BW-1:0] brightness = '0;
    logic [7:0]    seg_out;
    logic [N-1:0]  an;
    logic          frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference model state: output cycles since reset release, and the
    // brightness captured at the start of the current slot.
    int            t = 0;
    int            mbright = 0;

    ssd_scan_ctrl #(
        .N_DIGITS(N),
        .STEP_CYCLES(STEP),
        .BRIGHT_W(BW),
        .BLINK_FRAMES(BF),
        .ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .seg_in(seg_in),
        .digit_en(digit_en),
        .blink_en(blink_en),
        .brightness(brightness),
        .seg_out(seg_out),
        .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d, time %0t)", nm, got, exp, t, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("reset_an", 32'(an), 32'hF);
        chk("reset_seg", 32'(seg_out), 32'hFF);
        chk("reset_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
        t = 0;
        mbright = 0;
    endtask

    // Computes the expected pin state for the next edge from the current
    // inputs and the cycle position, then advances one clock and compares.
    task automatic run_cycle();
        logic [3:0] ea;
        logic [7:0] es;
        logic       et;
        int pos, pwm, d, ph;
        logic lit;
        if (reset) begin
            ea = 4'hF; es = 8'hFF; et = 1'b0;
        end else begin
            pos = t % SLOT;
            pwm = pos / STEP;
            d   = (t / SLOT) % N;
            ph  = ((t / FRAME) / BF) % 2;
            if (pos == 0) mbright = int'(brightness);
            lit = digit_en[d] && !(blink_en[d] && ph == 1) && (pwm <= mbright);
            ea  = lit ? ~(4'b0001 << d) : 4'hF;
            es  = lit ? ~seg_in[8*d +: 8] : 8'hFF;
            et  = ((t % FRAME) == 0);
        end
        @(posedge clk); #1;
        if (reset) t = 0; else t++;
        chk("model_an", 32'(an), 32'(ea));
        chk("model_seg", 32'(seg_out), 32'(es));
        chk("model_tick", 32'(frame_tick), 32'(et));
    endtask

    typedef struct {
        logic [31:0] seg;
        logic [3:0]  den;
        logic [3:0]  ben;
        logic [1:0]  br;
        logic [3:0]  an_exp;
        logic [7:0]  seg_exp;
        int          lit_cycles;
        logic        tick;
    } vec_t;

    vec_t tbl[10];

    initial begin
        // One record per slot, applied back to back from the first slot after reset.
        tbl[0] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd3, 4'b1110, 8'h86, 8, 1'b1};
        tbl[1] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd3, 4'b1101, 8'hF9, 8, 1'b0};
        tbl[2] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd3, 4'b1011, 8'hA4, 8, 1'b0};
        tbl[3] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd3, 4'b0111, 8'hB0, 8, 1'b0};
        tbl[4] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd1, 4'b1110, 8'h86, 4, 1'b1};
        tbl[5] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd1, 4'b1101, 8'hF9, 4, 1'b0};
        tbl[6] = '{32'h4F5B0679, 4'hB, 4'h0, 2'd3, 4'b1111, 8'hFF, 0, 1'b0};
        tbl[7] = '{32'h4F5B0679, 4'hF, 4'h0, 2'd0, 4'b0111, 8'hB0, 2, 1'b0};
        tbl[8] = '{32'h4F5B0679, 4'hF, 4'h2, 2'd3, 4'b1110, 8'h86, 8, 1'b1};
        tbl[9] = '{32'h4F5B0679, 4'hF, 4'h2, 2'd3, 4'b1111, 8'hFF, 0, 1'b0};

        repeat (2) @(posedge clk);
        #1;
        do_reset();

        for (int r = 0; r < 10; r++) begin
            seg_in     = tbl[r].seg;
            digit_en   = tbl[r].den;
            blink_en   = tbl[r].ben;
            brightness = tbl[r].br;
            for (int c = 0; c < SLOT; c++) begin
                @(posedge clk); #1;
                chk("tbl_an", 32'(an), (c < tbl[r].lit_cycles) ? 32'(tbl[r].an_exp) : 32'hF);
                chk("tbl_seg", 32'(seg_out), (c < tbl[r].lit_cycles) ? 32'(tbl[r].seg_exp) : 32'hFF);
                chk("tbl_tick", 32'(frame_tick), (c == 0) ? 32'(tbl[r].tick) : 32'h0);
            end
        end

        // Reset pulse in the middle of slot 3, then restart from digit 0.
        do_reset();
        seg_in = 32'h4F5B0679; digit_en = 4'hF; blink_en = 4'h0; brightness = 2'd3;
        for (int c = 0; c < 27; c++) run_cycle();
        reset = 1'b1;
        run_cycle();
        chk("midreset_an", 32'(an), 32'hF);
        chk("midreset_seg", 32'(seg_out), 32'hFF);
        chk("midreset_tick", 32'(frame_tick), 32'h0);
        reset = 1'b0;
        for (int c = 0; c < SLOT; c++) begin
            run_cycle();
            chk("restart_an", 32'(an), 32'hE);
            chk("restart_tick", 32'(frame_tick), (c == 0) ? 32'h1 : 32'h0);
        end

        // Brightness drop mid-slot applies only from the following slot.
        for (int c = 0; c < SLOT; c++) begin
            if (c == 3) brightness = 2'd0;
            run_cycle();
            chk("brt_hold_an", 32'(an), 32'hD);
        end
        for (int c = 0; c < SLOT; c++) begin
            run_cycle();
            chk("brt_next_an", 32'(an), (c < 2) ? 32'hB : 32'hF);
        end

        // Randomized inputs with occasional resets against the reference model.
        for (int c = 0; c < 700; c++) begin
            seg_in     = $urandom;
            digit_en   = 4'($urandom);
            blink_en   = 4'($urandom);
            brightness = 2'($urandom);
            reset      = ($urandom_range(0, 80) == 0);
            run_cycle();
        end
        reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
